// File: rtl/inv_shift_rows_serial.sv
// Purpose : column-serial (Inv)ShiftRows over a 4x4 AES state, ping-pong buffered so one block fills while the other drains.
// Latency : out_valid rises the cycle after input column 3 is accepted (4 cycles minimum from column 0); sustains 1 column/cycle.
// Backpr. : in_ready drops only while both banks are full; out_data/out_last hold while out_valid & !out_ready.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset (clears banks, flags, pointers)
//   clear             synchronous flush of all buffered/partial blocks; any same-cycle transfer is dropped
//   in_valid/in_ready input column handshake, in_data = {s0c, s1c, s2c, s3c}, columns 0..3 in order
//   out_valid/out_ready output column handshake, out_data packed like in_data, out_last on column 3
//   busy              a bank holds a complete block or a partial block is being written
module inv_shift_rows_serial #(
    parameter bit INVERSE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    // Column offsets for rows 1..3. Row r of output column c is taken from
    // input column (c - r*k) mod 4, with k = +1 (inverse) or k = -1 (forward).
    localparam logic [1:0] OFS_R1 = INVERSE ? 2'd1 : 2'd3;
    localparam logic [1:0] OFS_R2 = 2'd2;
    localparam logic [1:0] OFS_R3 = INVERSE ? 2'd3 : 2'd1;

    logic [31:0] bank [2][4];
    logic [1:0]  full;
    logic        wr_bank;
    logic        rd_bank;
    logic [1:0]  wr_col;
    logic [1:0]  rd_col;

    logic        wr_fire;
    logic        rd_fire;
    logic [1:0]  idx_r1;
    logic [1:0]  idx_r2;
    logic [1:0]  idx_r3;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    assign busy      = full[0] | full[1] | (wr_col != 2'd0);
    assign out_last  = out_valid && (rd_col == 2'd3);

    // 2-bit wrap-around gives the mod-4 column index directly.
    assign idx_r1 = rd_col - OFS_R1;
    assign idx_r2 = rd_col - OFS_R2;
    assign idx_r3 = rd_col - OFS_R3;

    assign out_data = {bank[rd_bank][rd_col][31:24],
                       bank[rd_bank][idx_r1][23:16],
                       bank[rd_bank][idx_r2][15:8],
                       bank[rd_bank][idx_r3][7:0]};

    // Write and read completions may land in the same cycle; they always
    // address different banks because a write needs !full and a read needs full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 4; c++) begin
                    bank[b][c] <= '0;
                end
            end
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_col  <= '0;
            rd_col  <= '0;
        end else if (clear) begin
            // Bank contents are deliberately kept; only control state flushes.
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_col  <= '0;
            rd_col  <= '0;
        end else begin
            if (wr_fire) begin
                bank[wr_bank][wr_col] <= in_data;
                wr_col                <= wr_col + 2'd1;
                if (wr_col == 2'd3) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 2'd1;
                if (rd_col == 2'd3) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Purpose : self-checking bench for inv_shift_rows_serial (inverse, forward and forward->inverse round trip).
// Latency : expected columns are queued when a block's last column is accepted and popped on each output transfer.
// Backpr. : the bench drives out_ready directly for the inverse instance; the round-trip chain is always ready.
module tb_inv_shift_rows_serial;

    typedef logic [31:0] blk_t [4];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    logic        f_in_valid = 1'b0;
    logic [31:0] f_in_data = '0;
    logic        f_in_ready;
    logic        f_out_valid;
    logic [31:0] f_out_data;
    logic        f_out_last;
    logic        f_busy;

    logic        rt_in_ready;
    logic        rt_out_valid;
    logic        rt_out_ready = 1'b1;
    logic [31:0] rt_out_data;
    logic        rt_out_last;
    logic        rt_busy;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int cyc = 0;
    bit contig_on = 1'b0;
    int contig_n = 0;
    int last_cyc = 0;

    logic [32:0] q_inv [$];
    logic [32:0] q_fwd [$];
    logic [32:0] q_rt  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    inv_shift_rows_serial #(.INVERSE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    inv_shift_rows_serial #(.INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(rt_in_ready), .out_data(f_out_data),
        .out_last(f_out_last), .busy(f_busy)
    );

    inv_shift_rows_serial #(.INVERSE(1'b1)) dut_rt (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(f_out_valid), .in_ready(rt_in_ready), .in_data(f_out_data),
        .out_valid(rt_out_valid), .out_ready(rt_out_ready), .out_data(rt_out_data),
        .out_last(rt_out_last), .busy(rt_busy)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference (Inv)ShiftRows: row r of output column c comes from column (c -/+ r) mod 4.
    function automatic logic [31:0] shift_col(input blk_t b, input int c, input bit inv);
        logic [31:0] res;
        logic [1:0]  src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            src = inv ? 2'(c - r) : 2'(c + r);
            res[31-8*r -: 8] = b[src][31-8*r -: 8];
        end
        return res;
    endfunction

    // Output monitors sample on the falling edge; a transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            assert (q_inv.size() > 0) else begin
                errors++;
                $error("FAIL inv_spurious: observed=%h expected=none", out_data);
            end
            if (q_inv.size() > 0) check("inv_out", {out_last, out_data}, q_inv.pop_front());
            if (contig_on) begin
                if (contig_n > 0) check("b2b_contig", 33'(cyc), 33'(last_cyc + 1));
                last_cyc = cyc;
                contig_n++;
                if (contig_n == 12) contig_on = 1'b0;
            end
        end
        if (f_out_valid && rt_in_ready) begin
            checks++;
            assert (q_fwd.size() > 0) else begin
                errors++;
                $error("FAIL fwd_spurious: observed=%h expected=none", f_out_data);
            end
            if (q_fwd.size() > 0) check("fwd_out", {f_out_last, f_out_data}, q_fwd.pop_front());
        end
        if (rt_out_valid && rt_out_ready) begin
            checks++;
            assert (q_rt.size() > 0) else begin
                errors++;
                $error("FAIL rt_spurious: observed=%h expected=none", rt_out_data);
            end
            if (q_rt.size() > 0) check("roundtrip_out", {rt_out_last, rt_out_data}, q_rt.pop_front());
        end
    end

    task automatic send_col(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        stall_cnt += n;
        check("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_fwd_col(input logic [31:0] d);
        int n = 0;
        f_in_valid = 1'b1;
        f_in_data  = d;
        @(negedge clk);
        while (!f_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fwd_send_accept", f_in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input blk_t b, input bit push);
        for (int c = 0; c < 4; c++) send_col(b[c]);
        if (push) begin
            for (int c = 0; c < 4; c++) q_inv.push_back({c == 3, shift_col(b, c, 1'b1)});
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q_inv.size() != 0 || q_fwd.size() != 0 || q_rt.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drain"}, 33'(q_inv.size() + q_fwd.size() + q_rt.size()), 33'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        blk_t std_b;
        blk_t rb;
        std_b = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

        // Reset state
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forward mode, then forward -> inverse must return the original block
        for (int c = 0; c < 4; c++) send_fwd_col(std_b[c]);
        f_in_valid = 1'b0;
        q_fwd.push_back({1'b0, 32'h00050A0F});
        q_fwd.push_back({1'b0, 32'h04090E03});
        q_fwd.push_back({1'b0, 32'h080D0207});
        q_fwd.push_back({1'b1, 32'h0C01060B});
        for (int c = 0; c < 4; c++) q_rt.push_back({c == 3, std_b[c]});
        drain("fwd");

        // Basic inverse, no backpressure, with latency check
        out_ready = 1'b1;
        send_col(std_b[0]);
        send_col(std_b[1]);
        send_col(std_b[2]);
        check("lat_before_last", out_valid, 1'b0);
        send_col(std_b[3]);
        in_valid = 1'b0;
        q_inv.push_back({1'b0, 32'h000D0A07});
        q_inv.push_back({1'b0, 32'h04010E0B});
        q_inv.push_back({1'b0, 32'h0805020F});
        q_inv.push_back({1'b1, 32'h0C090603});
        check("lat_after_last", out_valid, 1'b1);
        drain("basic");

        // Three blocks back to back
        stall_cnt = 0;
        contig_n  = 0;
        contig_on = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) rb[i] = $urandom;
            send_block(rb, 1'b1);
        end
        in_valid = 1'b0;
        check("b2b_stalls", 33'(stall_cnt), 33'd0);
        drain("b2b");
        check("b2b_count", 33'(contig_n), 33'd12);

        // Backpressure: two blocks fill both banks
        out_ready = 1'b0;
        send_block(std_b, 1'b1);
        for (int i = 0; i < 4; i++) rb[i] = $urandom;
        send_block(rb, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_hold", {out_last, out_data}, {1'b0, 32'h000D0A07});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("bp_reopen", in_ready, 1'b1);
        drain("bp");

        // Asynchronous reset after two input columns
        send_col(std_b[0]);
        send_col(std_b[1]);
        in_valid = 1'b0;
        check("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_data", out_data, 32'h0);
        q_inv.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rb[i] = $urandom;
        send_block(rb, 1'b1);
        in_valid = 1'b0;
        drain("post_rst");

        // clear with one bank full and one partial
        out_ready = 1'b0;
        send_block(std_b, 1'b0);
        for (int i = 0; i < 4; i++) rb[i] = $urandom;
        send_col(rb[0]);
        send_col(rb[1]);
        check("pre_clr_valid", out_valid, 1'b1);
        in_data = rb[2];
        clear   = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", out_valid, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) rb[i] = $urandom;
        send_block(rb, 1'b1);
        in_valid = 1'b0;
        drain("post_clr");
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
